// File: rtl/nn_argmax_reader.sv
// nn_argmax_reader
// Sweeps the NN core's output layer after each completion edge and reports the
// signed argmax (class index + peak activation) on a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_nn_finish           core completion flag, rising edge starts a sweep
//   o_opm_base            read base into core data RAM (constant OUT_BASE)
//   o_opm_offset          read offset, one new neuron per cycle while issuing
//   i_opm_dout            read data, valid RD_LAT cycles after the offset
//   o_res_valid           result available
//   i_res_ready           consumer accepts the result
//   o_res_class           index of the maximum neuron
//   o_res_max             value of the maximum neuron
//   o_busy                sweep in progress or result not yet accepted
//   o_overrun             sticky, completion edge seen while busy
//   i_clr_overrun         clears o_overrun (a coincident new event wins)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a completion edge
// S_ISSUE | presenting offsets 0..O_NUM-1, one per cycle
// S_DRAIN | waiting for the last in-flight reads to return
// S_DONE  | result presented, held until accepted

module nn_argmax_reader #(
  parameter int D_LEN     = 16,
  parameter int DA_AWIDTH = 10,
  parameter int OFS_WIDTH = 8,
  parameter int O_NUM     = 10,
  parameter int IDX_W     = 4,
  parameter int OUT_BASE  = 0,
  parameter int RD_LAT    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_nn_finish,
  output logic [DA_AWIDTH-1:0] o_opm_base,
  output logic [OFS_WIDTH-1:0] o_opm_offset,
  input  logic [D_LEN-1:0]     i_opm_dout,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [IDX_W-1:0]     o_res_class,
  output logic [D_LEN-1:0]     o_res_max,
  output logic                 o_busy,
  output logic                 o_overrun,
  input  logic                 i_clr_overrun
);

  localparam logic [OFS_WIDTH-1:0] LAST_OFS = OFS_WIDTH'(O_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_fin_prev;
  logic                 r_start;
  logic [OFS_WIDTH-1:0] r_offset;
  logic [RD_LAT-1:0]    r_vld;
  logic [IDX_W-1:0]     r_tag [RD_LAT];
  logic [IDX_W-1:0]     r_class;
  logic [D_LEN-1:0]     r_max;
  logic                 r_overrun;

  logic                 w_push;
  logic [RD_LAT-1:0]    w_vld_rest;
  logic                 w_drain_done;
  logic                 w_ret;
  logic [IDX_W-1:0]     w_ret_tag;
  logic                 w_better;

  // Everything except the oldest stage; once that is empty the read returning
  // this cycle is the last one, so DONE and the final max update share an edge.
  assign w_vld_rest   = r_vld << 1;
  assign w_drain_done = (w_vld_rest == '0);

  assign w_ret     = r_vld[RD_LAT-1];
  assign w_ret_tag = r_tag[RD_LAT-1];
  assign w_better  = $signed(i_opm_dout) > $signed(r_max);

  // Completion edge detector, registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fin_prev <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_fin_prev <= i_nn_finish;
      r_start    <= i_nn_finish & ~r_fin_prev;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_push = 1'b1;
        if (r_offset == LAST_OFS) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (i_res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue counter doubles as the offset register; it holds outside ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_offset <= '0;
    end else if (r_state == S_IDLE && r_start) begin
      r_offset <= '0;
    end else if (r_state == S_ISSUE && r_offset != LAST_OFS) begin
      r_offset <= r_offset + 1'b1;
    end
  end

  // Read-return tracker: one valid bit and index tag per outstanding read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= w_push;
      r_tag[0] <= IDX_W'(r_offset);
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Running argmax; strict compare keeps the lowest index on ties.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_class <= '0;
      r_max   <= '0;
    end else if (w_ret && (w_ret_tag == '0 || w_better)) begin
      r_class <= w_ret_tag;
      r_max   <= i_opm_dout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (r_start && r_state != S_IDLE) begin
      r_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_opm_base   = DA_AWIDTH'(OUT_BASE);
  assign o_opm_offset = r_offset;
  assign o_res_valid  = (r_state == S_DONE);
  assign o_res_class  = r_class;
  assign o_res_max    = r_max;
  assign o_busy       = (r_state != S_IDLE);
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_nn_argmax_reader.sv
// Testbench for nn_argmax_reader: main instance (RD_LAT=2) plus RD_LAT=1,
// RD_LAT=4 and O_NUM=1 instances sharing the start/reset stimulus.
module tb_nn_argmax_reader;

  localparam int D_LEN     = 16;
  localparam int DA_AWIDTH = 10;
  localparam int OFS_WIDTH = 8;
  localparam int O_NUM     = 10;
  localparam int IDX_W     = 4;
  localparam int OUT_BASE  = 0;
  localparam int RD_LAT    = 2;

  typedef struct packed {
    logic [IDX_W-1:0] cls;
    logic [D_LEN-1:0] mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nn_finish = 1'b0;
  logic res_ready = 1'b0;
  logic clr_overrun = 1'b0;
  logic aux_ready = 1'b1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [D_LEN-1:0] mem [256];
  exp_t sb_q[$];
  int n_total = 0;
  int n_bad = 0;

  // main DUT
  logic [DA_AWIDTH-1:0] base_m;
  logic [OFS_WIDTH-1:0] off_m;
  logic [D_LEN-1:0]     dout_m, mx_m;
  logic                 val_m, busy_m, ovr_m;
  logic [IDX_W-1:0]     cls_m;
  // RD_LAT=1
  logic [DA_AWIDTH-1:0] base_1;
  logic [OFS_WIDTH-1:0] off_1;
  logic [D_LEN-1:0]     dout_1, mx_1;
  logic                 val_1, busy_1, ovr_1;
  logic [IDX_W-1:0]     cls_1;
  // RD_LAT=4
  logic [DA_AWIDTH-1:0] base_4;
  logic [OFS_WIDTH-1:0] off_4;
  logic [D_LEN-1:0]     dout_4, mx_4;
  logic                 val_4, busy_4, ovr_4;
  logic [IDX_W-1:0]     cls_4;
  // O_NUM=1
  logic [DA_AWIDTH-1:0] base_n;
  logic [OFS_WIDTH-1:0] off_n;
  logic [D_LEN-1:0]     dout_n, mx_n;
  logic                 val_n, busy_n, ovr_n;
  logic [IDX_W-1:0]     cls_n;

  nn_argmax_reader #(.D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH), .OFS_WIDTH(OFS_WIDTH),
    .O_NUM(O_NUM), .IDX_W(IDX_W), .OUT_BASE(OUT_BASE), .RD_LAT(RD_LAT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(nn_finish), .o_opm_base(base_m),
    .o_opm_offset(off_m), .i_opm_dout(dout_m), .o_res_valid(val_m),
    .i_res_ready(res_ready), .o_res_class(cls_m), .o_res_max(mx_m),
    .o_busy(busy_m), .o_overrun(ovr_m), .i_clr_overrun(clr_overrun));

  nn_argmax_reader #(.D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH), .OFS_WIDTH(OFS_WIDTH),
    .O_NUM(O_NUM), .IDX_W(IDX_W), .OUT_BASE(OUT_BASE), .RD_LAT(1)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(nn_finish), .o_opm_base(base_1),
    .o_opm_offset(off_1), .i_opm_dout(dout_1), .o_res_valid(val_1),
    .i_res_ready(aux_ready), .o_res_class(cls_1), .o_res_max(mx_1),
    .o_busy(busy_1), .o_overrun(ovr_1), .i_clr_overrun(clr_overrun));

  nn_argmax_reader #(.D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH), .OFS_WIDTH(OFS_WIDTH),
    .O_NUM(O_NUM), .IDX_W(IDX_W), .OUT_BASE(OUT_BASE), .RD_LAT(4)) u_dut_l4 (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(nn_finish), .o_opm_base(base_4),
    .o_opm_offset(off_4), .i_opm_dout(dout_4), .o_res_valid(val_4),
    .i_res_ready(aux_ready), .o_res_class(cls_4), .o_res_max(mx_4),
    .o_busy(busy_4), .o_overrun(ovr_4), .i_clr_overrun(clr_overrun));

  nn_argmax_reader #(.D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH), .OFS_WIDTH(OFS_WIDTH),
    .O_NUM(1), .IDX_W(IDX_W), .OUT_BASE(OUT_BASE), .RD_LAT(2)) u_dut_n1 (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(nn_finish), .o_opm_base(base_n),
    .o_opm_offset(off_n), .i_opm_dout(dout_n), .o_res_valid(val_n),
    .i_res_ready(aux_ready), .o_res_class(cls_n), .o_res_max(mx_n),
    .o_busy(busy_n), .o_overrun(ovr_n), .i_clr_overrun(clr_overrun));

  // Read-port models: data appears RD_LAT clock edges after the offset.
  logic [D_LEN-1:0] p_m [2];
  logic [D_LEN-1:0] p_1;
  logic [D_LEN-1:0] p_4 [4];
  logic [D_LEN-1:0] p_n [2];
  always @(posedge clk) begin
    p_m[0] <= mem[off_m];  p_m[1] <= p_m[0];
    p_1    <= mem[off_1];
    p_4[0] <= mem[off_4];  p_4[1] <= p_4[0];  p_4[2] <= p_4[1];  p_4[3] <= p_4[2];
    p_n[0] <= mem[off_n];  p_n[1] <= p_n[0];
  end
  assign dout_m = p_m[1];
  assign dout_1 = p_1;
  assign dout_4 = p_4[3];
  assign dout_n = p_n[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    e.cls = '0;
    e.mx  = mem[0];
    for (int i = 1; i < n; i++) begin
      if (mem[i] > $signed(e.mx)) begin
        e.cls = IDX_W'(i);
        e.mx  = mem[i];
      end
    end
    return e;
  endfunction

  task automatic load(input int v[10], input bit push);
    for (int i = 0; i < 10; i++) mem[i] = D_LEN'(v[i]);
    if (push) sb_q.push_back(model(O_NUM));
  endtask

  task automatic take_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_class"}, 32'(cls_m), 32'(e.cls));
      chk({tag, "_max"}, 32'(mx_m), 32'(e.mx));
    end
  endtask

  // Returns just after edge T, where T registers the start edge (T = c0+1).
  task automatic pulse_start(output int c0);
    @(posedge clk); #1;
    nn_finish = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    nn_finish = 1'b0;
  endtask

  task automatic wait_valid(input int c0, input bit chk_ofs, output int d);
    int dd;
    d = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      dd = cyc - c0;
      if (chk_ofs && dd >= 2 && dd <= O_NUM + 1) chk("offset_step", 32'(off_m), 32'(dd - 2));
      if (val_m) begin
        d = dd;
        break;
      end
    end
    if (d < 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept_pulse(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_low"}, 32'(val_m), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy_m), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d, cnt, unstable;
    int d_m, d_1, d_4, d_n;
    exp_t e, e_full, e_one;
    int v1[10] = '{3, -7, 12, 5, 12, 0, -1, 9, 2, 4};
    int v2[10] = '{-5, -3, -9, -3, -32768, -10, -20, -32768, -7, -4};
    int v3[10] = '{7, 1, 2, 8, 3, 8, 0, -2, 5, 6};
    int v4[10] = '{-1, 4, 4, 2, 0, 3, 1, -8, 4, 2};
    int v5[10] = '{50, 60, 70, 80, 90, 10, 20, 30, 40, 55};
    int v6[10] = '{11, -22, 33, 44, -55, 66, 5, 77, 1, -88};
    int v7[10] = '{1, -2, 3, 4, 5, -6, 7, 8, 9, 100};

    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(val_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_overrun", 32'(ovr_m), 32'd0);
    chk("rst_offset", 32'(off_m), 32'd0);
    chk("rst_class", 32'(cls_m), 32'd0);
    chk("rst_max", 32'(mx_m), 32'd0);
    chk("base", 32'(base_m), 32'(OUT_BASE));
    chk("base_aux", 32'({base_1, base_4, base_n}), 32'd0);

    // mixed values, tie keeps lowest index, ready held high
    load(v1, 1'b1);
    res_ready = 1'b1;
    pulse_start(c0);
    wait_valid(c0, 1'b1, d);
    chk("t1_latency", 32'(d), 32'(O_NUM + RD_LAT + 2));
    take_result("t1");
    @(negedge clk);
    chk("t1_valid_low", 32'(val_m), 32'd0);
    chk("t1_busy_low", 32'(busy_m), 32'd0);
    res_ready = 1'b0;

    // all negative, back-pressure for 20 cycles
    load(v2, 1'b1);
    e = sb_q[0];
    pulse_start(c0);
    wait_valid(c0, 1'b0, d);
    take_result("t2");
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (val_m !== 1'b1 || cls_m !== e.cls || mx_m !== e.mx || busy_m !== 1'b1)
        unstable++;
    end
    chk("t2_hold_stable", 32'(unstable), 32'd0);
    chk("t2_max_after_hold", 32'(mx_m), 32'h0000_fffd);
    accept_pulse("t2");

    // nn_finish held high 50 cycles: one sweep only
    load(v3, 1'b1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    nn_finish = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 50) nn_finish = 1'b0;
      if (val_m) begin
        cnt++;
        if (cnt == 1) take_result("t3");
      end
    end
    chk("t3_one_result", 32'(cnt), 32'd1);
    chk("t3_no_overrun", 32'(ovr_m), 32'd0);
    res_ready = 1'b0;

    // second edge during DRAIN with a coincident clear: set wins
    load(v4, 1'b1);
    pulse_start(c0);
    repeat (O_NUM) @(posedge clk);
    #1 nn_finish = 1'b1;
    @(posedge clk); #1;
    nn_finish = 1'b0;
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("t4_overrun_set", 32'(ovr_m), 32'd1);
    wait_valid(c0, 1'b0, d);
    chk("t4_latency", 32'(d), 32'(O_NUM + RD_LAT + 2));
    take_result("t4");
    accept_pulse("t4");
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (val_m || busy_m) cnt++;
    end
    chk("t4_no_second_sweep", 32'(cnt), 32'd0);
    chk("t4_overrun_sticky", 32'(ovr_m), 32'd1);
    @(posedge clk); #1 clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    @(negedge clk);
    chk("t4_overrun_clr", 32'(ovr_m), 32'd0);

    // reset at offset 4 aborts the sweep
    load(v5, 1'b0);
    pulse_start(c0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_m && off_m == 8'd4) begin
        cnt = 1;
        break;
      end
    end
    chk("t5_reached_ofs4", 32'(cnt), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_outputs", 32'({off_m, val_m, busy_m, ovr_m}), 32'd0);
    chk("t5_rst_result", 32'({cls_m, mx_m}), 32'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (val_m || busy_m) cnt++;
    end
    chk("t5_no_result", 32'(cnt), 32'd0);
    load(v6, 1'b1);
    pulse_start(c0);
    wait_valid(c0, 1'b0, d);
    chk("t5_latency", 32'(d), 32'(O_NUM + RD_LAT + 2));
    take_result("t5");
    accept_pulse("t5");

    // max in last slot across read latencies, plus single-neuron build
    load(v7, 1'b1);
    e_full = model(O_NUM);
    e_one  = model(1);
    res_ready = 1'b1;
    pulse_start(c0);
    d_m = -1; d_1 = -1; d_4 = -1; d_n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (val_m && d_m < 0) begin
        d_m = cyc - c0;
        take_result("t6_l2");
      end
      if (val_1 && d_1 < 0) begin
        d_1 = cyc - c0;
        chk("t6_l1_class", 32'(cls_1), 32'(e_full.cls));
        chk("t6_l1_max", 32'(mx_1), 32'(e_full.mx));
      end
      if (val_4 && d_4 < 0) begin
        d_4 = cyc - c0;
        chk("t6_l4_class", 32'(cls_4), 32'(e_full.cls));
        chk("t6_l4_max", 32'(mx_4), 32'(e_full.mx));
      end
      if (val_n && d_n < 0) begin
        d_n = cyc - c0;
        chk("t6_n1_class", 32'(cls_n), 32'(e_one.cls));
        chk("t6_n1_max", 32'(mx_n), 32'(e_one.mx));
      end
    end
    res_ready = 1'b0;
    chk("t6_l2_latency", 32'(d_m), 32'(O_NUM + 2 + 2));
    chk("t6_l1_latency", 32'(d_1), 32'(O_NUM + 1 + 2));
    chk("t6_l4_latency", 32'(d_4), 32'(O_NUM + 4 + 2));
    chk("t6_n1_latency", 32'(d_n), 32'(1 + 2 + 2));
    @(negedge clk);
    chk("t6_all_idle", 32'({busy_m, busy_1, busy_4, busy_n}), 32'd0);
    chk("t6_aux_overrun", 32'({ovr_1, ovr_4, ovr_n}), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
